// File: rtl/spi_ram_pkg.sv
// Shared opcodes, FSM state type and default widths for the SPI-attached RAM controller.
package spi_ram_pkg;

    localparam int DEF_MEM_DEPTH = 256;
    localparam int DEF_ADDR_SIZE = 8;
    localparam int DEF_TX_HOLD   = 10;
    localparam int DATA_W        = 8;
    localparam int CMD_W         = 10;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port MEM_DEPTH x DATA_W storage with a registered read port.
// It has no reset, so synthesis can map it onto block RAM.
module spi_ram_array
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder and read-out FSM between the SPI slave and the RAM array.
// A rising edge of rx_valid loads the one-entry command slot; the slot executes the next cycle.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int TX_HOLD   = DEF_TX_HOLD
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [CMD_W-1:0]  rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid
);

    localparam int HOLD_W = $clog2(TX_HOLD + 1);

    state_e state_q, state_d;

    logic                 rx_valid_q;
    logic                 cmd_valid_q, cmd_valid_d;
    logic [1:0]           cmd_op_q, cmd_op_d;
    logic [DATA_W-1:0]    cmd_payload_q, cmd_payload_d;
    logic                 cmd_defer_q, cmd_defer_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0]    tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;

    logic                 fresh;
    logic                 exec;
    logic                 abort;
    logic                 mem_we;
    logic                 mem_re;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_W-1:0]    mem_rdata;

    // A command waits in the slot while the array read is in flight; commands that
    // arrived around a read (deferred) only cut the hold short if they are reads themselves.
    always_comb begin
        fresh = rx_valid && !rx_valid_q;
        exec  = cmd_valid_q && (state_q != RD);
        abort = exec && (state_q == HOLD) && (!cmd_defer_q || (cmd_op_q == OP_RD_DATA));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (exec && (cmd_op_q == OP_RD_DATA)) begin
                    state_d = RD;
                end
            end
            RD: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (abort) begin
                    state_d = (cmd_op_q == OP_RD_DATA) ? RD : IDLE;
                end else if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
            end
            RD: begin
                tx_valid_d = 1'b1;
                tx_data_d  = mem_rdata;
                hold_cnt_d = HOLD_W'(TX_HOLD - 1);
            end
            HOLD: begin
                if (abort || (hold_cnt_q == '0)) begin
                    tx_valid_d = 1'b0;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: begin
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_op_d      = cmd_op_q;
        cmd_payload_d = cmd_payload_q;
        cmd_defer_d   = cmd_defer_q;
        mem_we        = exec && (cmd_op_q == OP_WR_DATA);
        mem_re        = exec && (cmd_op_q == OP_RD_DATA);
        mem_addr      = (cmd_op_q == OP_WR_DATA) ? wr_addr_q : rd_addr_q;

        if (exec && (cmd_op_q == OP_WR_ADDR)) begin
            wr_addr_d = cmd_payload_q[ADDR_SIZE-1:0];
        end
        if (exec && (cmd_op_q == OP_RD_ADDR)) begin
            rd_addr_d = cmd_payload_q[ADDR_SIZE-1:0];
        end

        if (exec) begin
            cmd_valid_d = 1'b0;
        end
        // A full slot that is not draining this cycle drops the new command.
        if (fresh && (!cmd_valid_q || exec)) begin
            cmd_valid_d   = 1'b1;
            cmd_op_d      = rx_data[9:8];
            cmd_payload_d = rx_data[7:0];
            cmd_defer_d   = (state_q == RD) || (state_d == RD);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_valid_q    <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_op_q      <= OP_WR_ADDR;
            cmd_payload_q <= '0;
            cmd_defer_q   <= 1'b0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            hold_cnt_q    <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
        end else begin
            rx_valid_q    <= rx_valid;
            cmd_valid_q   <= cmd_valid_d;
            cmd_op_q      <= cmd_op_d;
            cmd_payload_q <= cmd_payload_d;
            cmd_defer_q   <= cmd_defer_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            hold_cnt_q    <= hold_cnt_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
        end
    end

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (cmd_payload_q),
        .rdata (mem_rdata)
    );

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Single-port RAM with command decode. Sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx_data / rx_valid words: 2-bit opcode plus 8-bit payload.
- Returns read bytes on tx_data / tx_valid, which the slave shifts out on MISO.
- Holds separate write and read address pointers, so address and data phases arrive as separate SPI frames.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words.
- ADDR_SIZE, 8, address width; MEM_DEPTH must equal 2**ADDR_SIZE.
- TX_HOLD, 10, cycles tx_valid/tx_data stay asserted after a read completes (covers the slave's 8-bit shift-out plus margin).

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- rx_data  in  10  command word; [9:8] opcode, [7:0] payload.
- rx_valid  in  1  rx_data valid; level, may stay high for several cycles per frame.
- tx_data  out  8  read data to the SPI slave.
- tx_valid  out  1  tx_data valid.

Behaviour:
- Reset (async, rstn=0) clears:
  - tx_data=0, tx_valid=0
  - wr_addr=0, rd_addr=0
  - hold counter=0, FSM=IDLE, rx_valid edge register=0
- The memory array is not reset; its contents are preserved across reset.

- Command acceptance:
  - A command is accepted only on the rising edge of rx_valid: rx_valid=1 and the registered previous value=0.
  - rx_data is sampled in that same cycle.
  - Further cycles with rx_valid held high are ignored.

- Opcodes:
  - 2'b00: wr_addr <= rx_data[7:0].
  - 2'b01: mem[wr_addr] <= rx_data[7:0]. wr_addr is unchanged, so repeated writes hit the same location.
  - 2'b10: rd_addr <= rx_data[7:0].
  - 2'b11: read mem[rd_addr]. rx_data[7:0] is don't-care. rd_addr is unchanged.
- Address width: only rx_data[ADDR_SIZE-1:0] is used; upper payload bits are ignored.
- An accepted write is visible to a read-data command accepted the following cycle or later.

- FSM states:
  - IDLE: tx_valid=0. An accepted opcode 11 goes to RD. Other opcodes stay in IDLE.
  - RD: synchronous array read issued. Next cycle: tx_data <= mem[rd_addr], tx_valid <= 1, hold counter <= TX_HOLD-1, go to HOLD.
  - HOLD: tx_data stable, tx_valid=1. Counter decrements each cycle. Counter==0 at a clock edge: tx_valid <= 0, go to IDLE. tx_data keeps its last value.
- Latency: opcode 11 accepted at edge N gives tx_valid=1 after edge N+2. It then stays high for exactly TX_HOLD cycles.

- Simultaneous events:
  - New accepted command while in HOLD: the hold aborts. tx_valid <= 0 at the next edge, except an opcode 11 re-enters RD with tx_valid dropping for exactly one cycle.
  - Any command accepted while in RD is latched and executed after RD. This is a one-entry pending slot; a second command while the slot is full is dropped.
  - Opcode 01 and opcode 11 never target the array in the same cycle; the pending slot serialises them.

- Reset mid-operation: immediate tx_valid=0 and FSM=IDLE; any pending command is discarded.
- Boundaries:
  - Address 8'hFF is valid; there is no wrap or auto-increment.
  - A read-data command without a prior read-address command reads address 0.

Decomposition:
- Package spi_ram_pkg holds:
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - FSM state typedef (IDLE, RD, HOLD).
  - Default widths.
- One sub-module, spi_ram_array:
  - MEM_DEPTH x 8 single-port array, one registered read port, write enable, no reset.
  - Lets synthesis infer block RAM.
- Command decode, edge detect, pending slot, FSM and hold counter stay in spi_ram_ctrl.

Test Plan:
- Write path: rx_valid pulse {00,8'h3C}, then {01,8'hA5}; then {10,8'h3C}, {11,8'h00} -> tx_valid rises 2 cycles after the last edge, tx_data=8'hA5 for exactly 10 cycles, then tx_valid=0.
- Level-held rx_valid: hold rx_valid high 12 cycles with {01,8'h11} after wr_addr=8'h05 -> a single write only; a following read of 8'h05 returns 8'h11, and the array shows no other writes.
- Read without address: after reset, write {00,00},{01,8'h7E}, then {11,xx} -> tx_data=8'h7E (rd_addr defaults 0).
- Abort hold: during HOLD (tx_data=8'hA5), accept {11,xx} with rd_addr pointing to 8'h5A -> tx_valid low for one cycle, then high with tx_data=8'h5A for 10 cycles.
- Async reset mid-HOLD: drop rstn between edges -> tx_valid=0 immediately; after release, read of 8'h3C still returns 8'hA5 (array unreset) but requires new address commands.
- Back-to-back: accept {01,8'hC3} in the cycle the FSM is in RD -> the write lands after RD; a subsequent read returns 8'hC3.
